if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/ifid_fifo2.sv | 73 +++++++
 rtl/if_id_stage.sv | 83 ++++++++
 tb/tb_if_id_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: field widths, bit positions, opcode/funct
// constants, the canonical NOP word and a field-decode helper.
package mips_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned IMM_W     = 16;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;

  localparam logic [INSTR_W-1:0] NOP_ENC = 32'h0000_0000;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    imm16;
  } fields_t;

  function automatic fields_t decode_fields(input logic [INSTR_W-1:0] instr);
    fields_t f;
    f.opcode = instr[OPCODE_LSB +: OPCODE_W];
    f.rs     = instr[RS_LSB     +: REG_W];
    f.rt     = instr[RT_LSB     +: REG_W];
    f.rd     = instr[RD_LSB     +: REG_W];
    f.shamt  = instr[SHAMT_LSB  +: SHAMT_W];
    f.funct  = instr[FUNCT_LSB  +: FUNCT_W];
    f.imm16  = instr[IMM_LSB    +: IMM_W];
    return f;
  endfunction

endpackage

// File: rtl/ifid_fifo2.sv
// Two-entry in-order {pc, instr} buffer with read/write pointers and an
// occupancy count; flush empties it and overrides any push/pop that cycle.
module ifid_fifo2
  import mips_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] wr_pc_i,
  input  logic [PC_W-1:0] wr_instr_i,
  output logic [1:0]      count_o,
  output logic [PC_W-1:0] head_pc_o,
  output logic [PC_W-1:0] head_instr_o
);

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0] pc_mem_q    [2];
  logic [PC_W-1:0] instr_mem_q [2];
  logic            do_push, do_pop;

  assign do_push = push_i && (count_q != 2'd2) && !flush_i;
  assign do_pop  = pop_i  && (count_q != 2'd0) && !flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      pc_mem_q[wr_ptr_q]    <= wr_pc_i;
      instr_mem_q[wr_ptr_q] <= wr_instr_i;
    end
  end

  assign count_o      = count_q;
  assign head_pc_o    = pc_mem_q[rd_ptr_q];
  assign head_instr_o = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register as a 2-entry skid buffer with MIPS field decode.
// Optional decode stall counter enabled by defining IFID_STALL_CNT_EN.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [PC_W-1:0] if_pc,
  input  logic [PC_W-1:0] if_instr,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [PC_W-1:0] id_pc4,
  output logic [5:0]      id_opcode,
  output logic [4:0]      id_rs,
  output logic [4:0]      id_rt,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_shamt,
  output logic [5:0]      id_funct,
  output logic [15:0]     id_imm16
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  logic [1:0]      count;
  logic [PC_W-1:0] head_pc, head_instr, instr_sel;
  logic            push, pop;
  fields_t         fields;

  assign if_ready = (count != 2'd2);
  assign id_valid = (count != 2'd0);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready;

  ifid_fifo2 #(.PC_W(PC_W)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_i       (push),
    .pop_i        (pop),
    .wr_pc_i      (if_pc),
    .wr_instr_i   (if_instr),
    .count_o      (count),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr)
  );

  assign instr_sel = id_valid ? head_instr : NOP_INSTR;
  assign fields    = decode_fields(instr_sel[INSTR_W-1:0]);
  assign id_pc4    = id_valid ? (head_pc + PC_W'(4)) : '0;

  assign id_opcode = fields.opcode;
  assign id_rs     = fields.rs;
  assign id_rt     = fields.rt;
  assign id_rd     = fields.rd;
  assign id_shamt  = fields.shamt;
  assign id_funct  = fields.funct;
  assign id_imm16  = fields.imm16;

`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: queue-based reference model plus
// directed scenarios and randomized traffic.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, if_ready, flush, id_valid, id_ready;
  logic [31:0] if_pc, if_instr, id_pc4;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] id_imm16;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int unsigned exp_stall = 0;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [63:0] model_q[$];

  always #5 clk = ~clk;

  if_id_stage #(.PC_W(32), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc4(id_pc4),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16)
`ifdef IFID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ins, pc;
    logic [47:0] exp_f;
    ins = (model_q.size() > 0) ? model_q[0][31:0] : 32'h0;
    pc  = (model_q.size() > 0) ? model_q[0][63:32] + 32'd4 : 32'h0;
    exp_f = {ins[31:26], ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[5:0], ins[15:0]};
    check("id_valid", {63'd0, id_valid}, {63'd0, model_q.size() != 0});
    check("if_ready", {63'd0, if_ready}, {63'd0, model_q.size() != 2});
    check("id_pc4", {32'd0, id_pc4}, {32'd0, pc});
    check("fields", {16'd0, id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm16},
          {16'd0, exp_f});
`ifdef IFID_STALL_CNT_EN
    check("stall_cnt", {48'd0, stall_cnt}, 64'(exp_stall));
`endif
  endtask

  // Entered and left at negedge; outputs depend only on registered state.
  task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic fl, input logic rdy, input logic rn);
    int unsigned sz;
    if_valid = v; if_pc = pc; if_instr = ins; flush = fl; id_ready = rdy; rst_n = rn;
    check_outputs();
    @(posedge clk);
    sz = model_q.size();
    if (!rn) begin
      model_q.delete();
`ifdef IFID_STALL_CNT_EN
      exp_stall = 0;
`endif
    end else begin
`ifdef IFID_STALL_CNT_EN
      if (sz > 0 && !rdy && exp_stall < 65535) exp_stall++;
`endif
      if (fl) model_q.delete();
      else begin
        if (sz > 0 && rdy) void'(model_q.pop_front());
        if (v && sz < 2) model_q.push_back({pc, ins});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] base;
    rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0; id_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tick(0, 0, 0, 0, 0, 0);
    // Reset state
    check("rst_valid", {63'd0, id_valid}, 64'd0);
    check("rst_ready", {63'd0, if_ready}, 64'd1);
    check("rst_pc4", {32'd0, id_pc4}, 64'd0);

    // Single push, next-cycle visibility and decode
    tick(1, 32'h0040_0000, 32'h2108_FFFF, 0, 1, 1);
    check("d_valid", {63'd0, id_valid}, 64'd1);
    check("d_pc4", {32'd0, id_pc4}, 64'h0040_0004);
    check("d_opcode", {58'd0, id_opcode}, 64'h08);
    check("d_rs", {59'd0, id_rs}, 64'd8);
    check("d_rt", {59'd0, id_rt}, 64'd8);
    check("d_imm16", {48'd0, id_imm16}, 64'hFFFF);
    tick(0, 0, 0, 0, 1, 1);

    // Back-pressure: three offered, two held, drain in order
    tick(1, 32'h100, 32'h0123_4567, 0, 0, 1);
    tick(1, 32'h104, 32'h89AB_CDEF, 0, 0, 1);
    check("bp_full", {63'd0, if_ready}, 64'd0);
    tick(1, 32'h108, 32'h1357_9BDF, 0, 0, 1);
    check("bp_head", {32'd0, id_pc4}, 64'h104);
    tick(0, 0, 0, 0, 1, 1);
    check("bp_second", {32'd0, id_pc4}, 64'h108);
    tick(0, 0, 0, 0, 1, 1);
    check("bp_empty", {63'd0, id_valid}, 64'd0);

    // Streaming at count 1
    tick(1, 32'h200, 32'hAAAA_0000, 0, 0, 1);
    for (int i = 1; i <= 10; i++) tick(1, 32'h200 + 32'(4 * i), $urandom, 0, 1, 1);
    check("stream_pc4", {32'd0, id_pc4}, 64'h200 + 64'd44);
    tick(0, 0, 0, 0, 1, 1);

    // Flush at count 2 with a concurrent offer
    tick(1, 32'h300, $urandom, 0, 0, 1);
    tick(1, 32'h304, $urandom, 0, 0, 1);
    tick(1, 32'h308, $urandom, 1, 1, 1);
    check("fl_valid", {63'd0, id_valid}, 64'd0);
    check("fl_ready", {63'd0, if_ready}, 64'd1);

    // PC wrap and mid-stream reset
    tick(1, 32'hFFFF_FFFC, $urandom, 0, 0, 1);
    check("wrap_pc4", {32'd0, id_pc4}, 64'd0);
    check("wrap_valid", {63'd0, id_valid}, 64'd1);
    tick(1, 32'h400, $urandom, 0, 0, 1);
    tick(1, 32'h404, $urandom, 0, 1, 0);
    check("midrst_valid", {63'd0, id_valid}, 64'd0);

    // Randomized traffic
    base = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) != 0, base, $urandom, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) != 0);
      base = base + 32'd4;
    end

`ifdef IFID_STALL_CNT_EN
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 32'h500, $urandom, 0, 0, 1);
    for (int i = 0; i < 70000; i++) tick(0, 0, 0, 0, 0, 1);
    check("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 1);
    check("stall_hold", {48'd0, stall_cnt}, 64'hFFFF);
`endif

    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
